// File: rtl/a2d_spi_intf_pkg.sv
// a2d_pkg: shared types and constants for the ADC128S SPI master.
//   state_t        frame-sequencing FSM states
//   SCLK_DIV_INIT  divider preload giving a 9-clk front porch before the first SCLK fall
//   FRAME_BITS     bits per SPI frame
//   CMD_PAD        trailing don't-care bits of the command word
//   make_cmd()     builds the 16-bit command word for a channel
package a2d_pkg;

    typedef enum logic [2:0] {IDLE, FRAME1, GAP, FRAME2} state_t;

    localparam logic [4:0]  SCLK_DIV_INIT = 5'b10111;
    localparam int          FRAME_BITS    = 16;
    localparam logic [10:0] CMD_PAD       = 11'h000;

    // ADC128S control byte: two don't-care bits, then ADD2..ADD0.
    function automatic logic [15:0] make_cmd(input logic [2:0] ch);
        return {2'b00, ch, CMD_PAD};
    endfunction

endpackage

// File: rtl/a2d_spi_intf_spi_frame16.sv
// spi_frame16: runs one 16-bit SPI frame (mode 3, SCLK idles high).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        one-cycle pulse: load cmd and begin a frame
//   cmd          16-bit word shifted out MSB first
//   MISO         serial data in, sampled on SCLK rise
//   SCLK         SPI clock, div MSB while a frame is active, high otherwise
//   MOSI         serial data out (MSB of the shift register)
//   data         received word including the bit completing on this edge
//   frame_done   high on the edge that performs the 16th shift
module spi_frame16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SCLK,
    output logic        MOSI,
    output logic [15:0] data,
    output logic        frame_done
);

    localparam logic [SCLK_DIV_W-1:0] DIV_INIT = SCLK_DIV_W'(SCLK_DIV_INIT);
    // div value just before SCLK rises / falls
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;

    logic [SCLK_DIV_W-1:0] div;
    logic [15:0]           shreg;
    logic [4:0]            shift_cnt;
    logic                  active;
    logic                  rose;      // a rise has occurred since the last fall
    logic                  miso_smp;
    logic                  shift_now;

    // The front-porch fall has no preceding rise, so it never shifts.
    assign shift_now  = active && rose && (div == DIV_FALL);
    assign frame_done = shift_now && (shift_cnt == 5'(FRAME_BITS - 1));
    assign data       = {shreg[14:0], miso_smp};
    assign SCLK       = ~active | div[SCLK_DIV_W-1];
    assign MOSI       = shreg[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '1;
            shreg     <= '0;
            shift_cnt <= '0;
            active    <= 1'b0;
            rose      <= 1'b0;
            miso_smp  <= 1'b0;
        end else if (start) begin
            div       <= DIV_INIT;
            shreg     <= cmd;
            shift_cnt <= '0;
            active    <= 1'b1;
            rose      <= 1'b0;
        end else if (active) begin
            div <= div + 1'b1;
            if (div == DIV_RISE) begin
                miso_smp <= MISO;
                rose     <= 1'b1;
            end
            if (shift_now) begin
                shreg     <= data;
                rose      <= 1'b0;
                shift_cnt <= shift_cnt + 5'd1;
                // Dropping active on the last shift holds SCLK high.
                if (frame_done) active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/a2d_spi_intf.sv
// a2d_spi_intf: SPI master for the ADC128S. One strt_cnv request runs two
// identical frames separated by a SS_n-high gap; the second frame carries the
// result of the requested channel (the ADC is pipelined by one frame).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   strt_cnv     one-cycle request, accepted only in IDLE
//   chnnl        channel, captured on the accepting edge
//   cnv_cmplt    level, set at completion, cleared by the next accepted request
//   res          12-bit result, updated only at completion
//   a2d_SS_n     slave select, active low
//   SCLK, MOSI   SPI clock / data out
//   MISO         SPI data in
module a2d_spi_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5,
    parameter int GAP_CYC    = 32,
    parameter int RES_W      = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt_cnv,
    input  logic [2:0]       chnnl,
    output logic             cnv_cmplt,
    output logic [RES_W-1:0] res,
    output logic             a2d_SS_n,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO
);

    localparam int GAP_W = $clog2(GAP_CYC + 1);

    state_t           state, next_state;
    logic             frame_start;
    logic             frame_done;
    logic [2:0]       chnnl_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      cmd;
    logic [15:0]      data;
    logic [15-RES_W:0] unused_lead;

    // Leading bits of the ADC word are always zero.
    assign unused_lead = data[15:RES_W];

    // On the accepting edge chnnl_lat is not loaded yet, so use chnnl directly.
    assign cmd = make_cmd((state == IDLE) ? chnnl : chnnl_lat);

    spi_frame16 #(
        .SCLK_DIV_W (SCLK_DIV_W)
    ) u_frame (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (frame_start),
        .cmd        (cmd),
        .MISO       (MISO),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .data       (data),
        .frame_done (frame_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                if (strt_cnv) begin
                    next_state  = FRAME1;
                    frame_start = 1'b1;
                end
            end
            FRAME1: begin
                if (frame_done) next_state = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    next_state  = FRAME2;
                    frame_start = 1'b1;
                end
            end
            FRAME2: begin
                if (frame_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a2d_SS_n  <= 1'b1;
            cnv_cmplt <= 1'b0;
            res       <= '0;
            chnnl_lat <= '0;
            gap_cnt   <= '0;
        end else begin
            if (frame_start)     a2d_SS_n <= 1'b0;
            else if (frame_done) a2d_SS_n <= 1'b1;

            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;

            if (state == IDLE && strt_cnv) begin
                chnnl_lat <= chnnl;
                cnv_cmplt <= 1'b0;
            end

            if (state == FRAME2 && frame_done) begin
                res       <= data[RES_W-1:0];
                cnv_cmplt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_a2d_spi_intf.sv
// Testbench for a2d_spi_intf with a behavioural ADC128S model.
module tb_a2d_spi_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        MISO;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        a2d_SS_n;
    logic        SCLK;
    logic        MOSI;

    a2d_spi_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .a2d_SS_n  (a2d_SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sclk_edges = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(SCLK) sclk_edges++;

    // ADC128S model: returns the channel addressed in the previous frame
    logic [11:0] adc_val [8];
    logic [2:0]  next_ch = 3'd0;
    logic [15:0] adc_word = 16'h0;
    logic [3:0]  idx = 4'd15;
    int          rises = 0;
    logic [15:0] rx = 16'h0;
    time         t_fall = 0, t_rise = 0, porch = 0;
    bit          porch_seen = 0;

    logic [15:0] fr_word  [$];
    int          fr_rises [$];
    int          fr_low   [$];
    int          fr_porch [$];
    int          gap_q    [$];
    logic [11:0] exp_res_q [$];
    logic [15:0] exp_cmd_q [$];

    assign MISO = adc_word[idx];

    always @(negedge a2d_SS_n) begin
        if (t_rise != 0 && ($time - t_rise) < 1000) gap_q.push_back(int'(($time - t_rise) / 10));
        t_fall = $time;
        rises = 0;
        rx = 16'h0;
        porch_seen = 0;
        adc_word = {4'h0, adc_val[next_ch]};
        idx = 4'd15;
    end

    always @(posedge SCLK) if (a2d_SS_n === 1'b0) begin
        rises++;
        rx = {rx[14:0], MOSI};
    end

    always @(negedge SCLK) if (a2d_SS_n === 1'b0) begin
        if (!porch_seen) begin
            porch_seen = 1;
            porch = $time - t_fall;
        end
        if (rises > 0 && idx != 0) idx = idx - 4'd1;
    end

    always @(posedge a2d_SS_n) begin
        t_rise = $time;
        if (rises == 16) next_ch = rx[13:11];
        fr_word.push_back(rx);
        fr_rises.push_back(rises);
        fr_low.push_back(int'((t_rise - t_fall) / 10));
        fr_porch.push_back(int'(porch / 10));
    end

    task automatic clear_mon();
        fr_word.delete(); fr_rises.delete(); fr_low.delete(); fr_porch.delete(); gap_q.delete();
        exp_cmd_q.delete();
    endtask

    task automatic do_request(input logic [2:0] ch, output int acc);
        @(negedge clk);
        strt_cnv = 1'b1;
        chnnl = ch;
        @(negedge clk);
        strt_cnv = 1'b0;
        acc = cyc;
        exp_res_q.push_back(adc_val[ch]);
        exp_cmd_q.push_back({2'b00, ch, 11'h000});
        exp_cmd_q.push_back({2'b00, ch, 11'h000});
    endtask

    task automatic wait_cmplt(input int acc, output int lat, output bit ok);
        ok = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1) begin
                ok = 1;
                break;
            end
        end
        lat = cyc - acc;
    endtask

    task automatic test_reset();
        int e0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a2d_SS_n !== 1'b1) begin failures++; $display("FAIL rst_ss_n got=%b exp=1", a2d_SS_n); end
        checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL rst_sclk got=%b exp=1", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", MOSI); end
        checks++; if (cnv_cmplt !== 1'b0) begin failures++; $display("FAIL rst_cmplt got=%b exp=0", cnv_cmplt); end
        checks++; if (res !== 12'h000) begin failures++; $display("FAIL rst_res got=%h exp=000", res); end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        strt_cnv = 1'b1; chnnl = 3'd2;
        @(negedge clk); strt_cnv = 1'b0;
        repeat (100) @(negedge clk);
        checks++; if (a2d_SS_n !== 1'b0) begin failures++; $display("FAIL midframe_ss_n got=%b exp=0", a2d_SS_n); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a2d_SS_n !== 1'b1) begin failures++; $display("FAIL abort_ss_n got=%b exp=1", a2d_SS_n); end
        checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL abort_sclk got=%b exp=1", SCLK); end
        checks++; if (cnv_cmplt !== 1'b0) begin failures++; $display("FAIL abort_cmplt got=%b exp=0", cnv_cmplt); end
        e0 = sclk_edges;
        @(negedge clk); rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (sclk_edges !== e0) begin failures++; $display("FAIL post_rst_sclk_edges got=%0d exp=%0d", sclk_edges, e0); end
        checks++; if (a2d_SS_n !== 1'b1) begin failures++; $display("FAIL post_rst_ss_n got=%b exp=1", a2d_SS_n); end
    endtask

    task automatic test_frames(input logic [2:0] ch, input string nm);
        int acc, lat;
        bit ok;
        logic [11:0] e;
        repeat (150) @(negedge clk);
        clear_mon();
        do_request(ch, acc);
        wait_cmplt(acc, lat, ok);
        checks++; if (!ok) begin failures++; $display("FAIL %s_timeout cnv_cmplt=%b exp=1", nm, cnv_cmplt); end
        checks++; if (lat !== 1074) begin failures++; $display("FAIL %s_latency got=%0d exp=1074", nm, lat); end
        e = exp_res_q.pop_front();
        checks++; if (res !== e) begin failures++; $display("FAIL %s_res got=%h exp=%h", nm, res, e); end
        checks++; if (fr_word.size() !== 2) begin failures++; $display("FAIL %s_frame_count got=%0d exp=2", nm, fr_word.size()); end
        for (int i = 0; i < 2 && fr_word.size() > 0; i++) begin
            logic [15:0] w, ew;
            int r, l, p;
            w = fr_word.pop_front(); r = fr_rises.pop_front(); l = fr_low.pop_front(); p = fr_porch.pop_front();
            ew = exp_cmd_q.pop_front();
            checks++; if (w !== ew) begin failures++; $display("FAIL %s_mosi_word%0d got=%h exp=%h", nm, i, w, ew); end
            checks++; if (r !== 16) begin failures++; $display("FAIL %s_rises%0d got=%0d exp=16", nm, i, r); end
            checks++; if (l !== 521) begin failures++; $display("FAIL %s_ss_low%0d got=%0d exp=521", nm, i, l); end
            checks++; if (p !== 9) begin failures++; $display("FAIL %s_porch%0d got=%0d exp=9", nm, i, p); end
        end
        checks++; if (gap_q.size() !== 1 || gap_q[0] !== 32) begin
            failures++; $display("FAIL %s_gap got=%0d entries first=%0d exp=32", nm, gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1);
        end
    endtask

    task automatic test_busy_ignore();
        int acc, lat;
        bit ok;
        logic [11:0] e;
        repeat (150) @(negedge clk);
        clear_mon();
        do_request(3'd1, acc);
        repeat (299) @(negedge clk);
        strt_cnv = 1'b1; chnnl = 3'd5;
        @(negedge clk); strt_cnv = 1'b0; chnnl = 3'd0;
        wait_cmplt(acc, lat, ok);
        checks++; if (!ok || lat !== 1074) begin failures++; $display("FAIL busy_latency got=%0d ok=%0d exp=1074", lat, ok); end
        e = exp_res_q.pop_front();
        checks++; if (res !== e) begin failures++; $display("FAIL busy_res got=%h exp=%h", res, e); end
        repeat (1200) @(negedge clk);
        checks++; if (fr_word.size() !== 2) begin failures++; $display("FAIL busy_frame_count got=%0d exp=2", fr_word.size()); end
        checks++; if (fr_word.size() > 1 && fr_word[1] !== 16'h0800) begin failures++; $display("FAIL busy_cmd got=%h exp=0800", fr_word[1]); end
        checks++; if (cnv_cmplt !== 1'b1 || res !== e) begin failures++; $display("FAIL busy_hold cmplt=%b res=%h exp=1/%h", cnv_cmplt, res, e); end
    endtask

    task automatic test_handshake();
        int acc, lat;
        bit ok;
        logic [11:0] e;
        logic [11:0] old_exp;
        old_exp = adc_val[1];
        clear_mon();
        do_request(3'd6, acc);
        checks++; if (cnv_cmplt !== 1'b0) begin failures++; $display("FAIL hs_clear got=%b exp=0", cnv_cmplt); end
        checks++; if (res !== old_exp) begin failures++; $display("FAIL hs_res_hold got=%h exp=%h", res, old_exp); end
        repeat (500) @(negedge clk);
        checks++; if (res !== old_exp || cnv_cmplt !== 1'b0) begin failures++; $display("FAIL hs_mid got res=%h cmplt=%b exp=%h/0", res, cnv_cmplt, old_exp); end
        wait_cmplt(acc, lat, ok);
        checks++; if (!ok) begin failures++; $display("FAIL hs_timeout cnv_cmplt=%b exp=1", cnv_cmplt); end
        e = exp_res_q.pop_front();
        checks++; if (res !== e) begin failures++; $display("FAIL hs_res got=%h exp=%h", res, e); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] chs [6];
        int acc, lat;
        bit ok;
        logic [11:0] e;
        logic [15:0] w, ew;
        chs = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
        for (int i = 0; i < 6; i++) adc_val[chs[i]] = 12'(12'h111 * (i + 1));
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            do_request(chs[i], acc);
            wait_cmplt(acc, lat, ok);
            e = exp_res_q.pop_front();
            checks++; if (!ok || res !== e) begin failures++; $display("FAIL seq%0d_res got=%h ok=%0d exp=%h", i, res, ok, e); end
            for (int k = 0; k < 2; k++) begin
                w = (fr_word.size() > 0) ? fr_word.pop_front() : 16'hxxxx;
                ew = exp_cmd_q.pop_front();
                checks++; if (w !== ew) begin failures++; $display("FAIL seq%0d_cmd%0d got=%h exp=%h", i, k, w, ew); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) adc_val[i] = 12'(12'h100 + i * 12'h011);
        test_reset();
        adc_val[3] = 12'hABC;
        test_frames(3'd3, "basic");
        adc_val[7] = 12'h5A7;
        test_frames(3'd7, "framing");
        adc_val[1] = 12'h3C1;
        adc_val[5] = 12'h0F5;
        test_busy_ignore();
        adc_val[6] = 12'h96E;
        test_handshake();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
